// File: rtl/axi_pkg.sv
// Shared AXI definitions for the cpu2axi bridge: burst encodings, the bridge
// FSM state type and the AxSIZE helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } cpu2axi_state_t;

  // AxSIZE encoding for a beat of nbytes bytes (ceil(log2(nbytes))).
  function automatic logic [2:0] size_from_bytes(input int unsigned nbytes);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) < nbytes) s = 3'(i + 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle (AR, R, AW, W, B). Every channel transfers a beat on a cycle
// where VALID and READY are both high; a source holds VALID and its payload
// stable until READY is seen, and VALID never waits on READY.
interface axi_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_W     = 4
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport m (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport s (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu2axi.sv
// Single-outstanding AXI4 master bridge. A core burst request becomes either
// AR + R beats (streamed straight through to the core) or AW + W beats + B.
// Addresses are word indices; bursts are INCR. The current FSM state is
// exported on dbg_state.
module cpu2axi
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int AXI_ID     = 0,
  localparam int STRB_W    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic [STRB_W-1:0]     req_wstrb,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  wr_done,
  output cpu2axi_state_t        dbg_state,
  axi_if.m                      axi_m
);

  cpu2axi_state_t        state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [STRB_W-1:0]     strb_q;
  logic [7:0]            beat_cnt;
  logic                  req_hs;
  logic                  w_hs;
  logic                  last_beat;

  assign req_hs    = (state == IDLE) && req_valid;
  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = (state == WR_DATA) && wdata_valid && axi_m.wready;
  assign dbg_state = state;

  // Address/control fields only change in IDLE, so they are stable while valid.
  assign axi_m.arid    = ID_WIDTH'(AXI_ID);
  assign axi_m.araddr  = addr_q;
  assign axi_m.arlen   = len_q;
  assign axi_m.arsize  = size_from_bytes(STRB_W);
  assign axi_m.arburst = BURST_INCR;
  assign axi_m.awid    = ID_WIDTH'(AXI_ID);
  assign axi_m.awaddr  = addr_q;
  assign axi_m.awlen   = len_q;
  assign axi_m.awsize  = size_from_bytes(STRB_W);
  assign axi_m.awburst = BURST_INCR;
  assign axi_m.wdata   = wdata;
  assign axi_m.wstrb   = strb_q;
  assign rdata         = axi_m.rdata;

  // State register plus the request latch and write beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      strb_q   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      if (req_hs) begin
        addr_q   <= req_addr;
        len_q    <= req_len;
        strb_q   <= req_wstrb;
        beat_cnt <= '0;
      end else if (w_hs && !last_beat) begin
        // Stop counting on the final beat so len=255 never wraps the counter.
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // Next-state logic and all per-state handshake outputs.
  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    axi_m.arvalid = 1'b0;
    axi_m.awvalid = 1'b0;
    axi_m.wvalid  = 1'b0;
    axi_m.wlast   = 1'b0;
    axi_m.rready  = 1'b0;
    axi_m.bready  = 1'b0;
    wdata_ready   = 1'b0;
    rdata_valid   = 1'b0;
    rdata_last    = 1'b0;
    wr_done       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = req_write ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: begin
        axi_m.arvalid = 1'b1;
        if (axi_m.arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        // Zero-latency pass-through; the burst ends on RLAST alone.
        rdata_valid  = axi_m.rvalid;
        rdata_last   = axi_m.rlast;
        axi_m.rready = rdata_ready;
        if (axi_m.rvalid && rdata_ready && axi_m.rlast) state_n = IDLE;
      end
      WR_ADDR: begin
        // W stays quiet until the address has been accepted.
        axi_m.awvalid = 1'b1;
        if (axi_m.awready) state_n = WR_DATA;
      end
      WR_DATA: begin
        axi_m.wvalid = wdata_valid;
        axi_m.wlast  = last_beat;
        wdata_ready  = axi_m.wready;
        if (w_hs && last_beat) state_n = WR_RESP;
      end
      WR_RESP: begin
        axi_m.bready = 1'b1;
        if (axi_m.bvalid) begin
          wr_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu2axi.sv
// Directed bench for cpu2axi with a small AXI RAM slave model attached.
module tb_cpu2axi;
  import axi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_write = 0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [3:0]  req_wstrb = '0;
  logic        wdata_valid = 0;
  logic [31:0] wdata = '0;
  logic        rdata_ready = 0;
  logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_done;
  logic [31:0] rdata;
  cpu2axi_state_t dbg_state;

  axi_if #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .STRB_W(4)) axi ();

  cpu2axi #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wstrb(req_wstrb),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .wr_done(wr_done), .dbg_state(dbg_state),
    .axi_m(axi)
  );

  // ---------------- AXI RAM slave model ----------------
  logic [31:0] mem [0:1023];
  logic        rd_active, wr_active, b_pending;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  rd_left;
  int          aw_cnt;
  int          aw_delay = 0;

  assign axi.arready = axi.arvalid && !rd_active;
  assign axi.rvalid  = rd_active;
  assign axi.rdata   = mem[rd_addr[9:0]];
  assign axi.rlast   = (rd_left == 8'd0);
  assign axi.rid     = '0;
  assign axi.rresp   = '0;
  assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
  assign axi.wready  = wr_active;
  assign axi.bvalid  = b_pending;
  assign axi.bid     = '0;
  assign axi.bresp   = '0;

  // Slave: preloads RAM on reset, serves one read and one write burst at a time.
  always @(posedge clk) begin
    if (rst) begin
      rd_active <= 0; wr_active <= 0; b_pending <= 0;
      rd_addr <= '0; wr_addr <= '0; rd_left <= '0; aw_cnt <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[16'h10] <= 32'hDEADBEEF;
      mem[16'h20] <= 32'h11223344;
      for (int i = 0; i < 8; i++) mem[16'h40 + i] <= 32'hA0 + i;
    end else begin
      if (axi.arvalid && axi.arready) begin
        rd_active <= 1; rd_addr <= axi.araddr; rd_left <= axi.arlen;
      end else if (axi.rvalid && axi.rready) begin
        rd_addr <= rd_addr + 16'd1;
        if (rd_left == 8'd0) rd_active <= 0;
        else rd_left <= rd_left - 8'd1;
      end
      if (axi.awvalid && axi.awready) begin
        wr_active <= 1; wr_addr <= axi.awaddr; aw_cnt <= 0;
      end else if (axi.awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (axi.wvalid && axi.wready) begin
        for (int b = 0; b < 4; b++)
          if (axi.wstrb[b]) mem[wr_addr[9:0]][8*b +: 8] <= axi.wdata[8*b +: 8];
        wr_addr <= wr_addr + 16'd1;
        if (axi.wlast) begin
          wr_active <= 0; b_pending <= 1;
        end
      end
      if (axi.bvalid && axi.bready) b_pending <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input bit toggle);
    bit got_last;
    got_last = 0;
    req_valid = 1; req_write = 0; req_addr = addr; req_len = len;
    settle();
    chk("rd_req_ready", req_ready, 1);
    cyc();
    req_valid = 0;
    settle();
    chk("arvalid", axi.arvalid, 1);
    chk("araddr", axi.araddr, addr);
    chk("arlen", axi.arlen, len);
    chk("arsize", axi.arsize, 2);
    chk("arburst", axi.arburst, 1);
    chk("arid", axi.arid, 0);
    chk("busy_req_ready", req_ready, 0);
    for (int n = 0; n < 700; n++) begin
      rdata_ready = toggle ? (n % 2 == 0) : 1'b1;
      settle();
      if (dbg_state == RD_DATA) chk("rready_mirror", axi.rready, rdata_ready);
      if (rdata_valid && rdata_ready) begin
        if (exp_q.size() == 0) begin
          chk("rd_extra_beat", 1, 0);
        end else begin
          chk("rdata", rdata, exp_q.pop_front());
          chk("rdata_last", rdata_last, exp_q.size() == 0);
          if (rdata_last) got_last = 1;
        end
      end
      cyc();
      if (got_last) break;
    end
    rdata_ready = 0;
    chk("rd_completed", got_last, 1);
    chk("rd_beats_left", exp_q.size(), 0);
    exp_q.delete();
    settle();
    chk("rd_back_idle", req_ready, 1);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] strb);
    bit done;
    bit aw_seen;
    int aw_cycles;
    done = 0; aw_seen = 0; aw_cycles = 0;
    req_valid = 1; req_write = 1; req_addr = addr; req_len = len; req_wstrb = strb;
    wdata_valid = 1; wdata = wr_q[0];
    settle();
    chk("wr_req_ready", req_ready, 1);
    cyc();
    req_valid = 0;
    for (int n = 0; n < 700; n++) begin
      if (wr_q.size() == 0) break;
      wdata = wr_q[0];
      settle();
      if (axi.awvalid) begin
        aw_cycles++;
        chk("w_before_aw", axi.wvalid, 0);
        chk("wready_before_aw", wdata_ready, 0);
        if (!aw_seen) begin
          aw_seen = 1;
          chk("awaddr", axi.awaddr, addr);
          chk("awlen", axi.awlen, len);
          chk("awsize", axi.awsize, 2);
          chk("awburst", axi.awburst, 1);
        end
      end
      if (axi.wvalid && wdata_ready) begin
        chk("wlast", axi.wlast, wr_q.size() == 1);
        void'(wr_q.pop_front());
        if (wr_q.size() == 0) done = 1;
      end
      cyc();
      if (done) break;
    end
    wdata_valid = 0;
    chk("wr_all_beats", done, 1);
    chk("aw_cycles", aw_cycles, aw_delay + 1);
    wr_q.delete();
    settle();
    chk("bready", axi.bready, 1);
    chk("wr_done_pulse", wr_done, 1);
    cyc();
    settle();
    chk("wr_done_low", wr_done, 0);
    chk("wr_back_idle", req_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) cyc();
    rst = 0;
    settle();
    chk("rst_state", dbg_state, IDLE);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_wr_done", wr_done, 0);

    // single read
    exp_q.push_back(32'hDEADBEEF);
    do_read(16'h0010, 8'd0, 0);

    // burst write of 1..4 then readback
    for (int i = 1; i <= 4; i++) wr_q.push_back(32'(i));
    do_write(16'h0100, 8'd3, 4'hF);
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    do_read(16'h0100, 8'd3, 0);

    // partial strobe over 0x11223344
    wr_q.push_back(32'hAABBCCDD);
    do_write(16'h0020, 8'd0, 4'b0101);
    exp_q.push_back(32'h11BB33DD);
    do_read(16'h0020, 8'd0, 0);

    // read backpressure, len=7
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA0 + i);
    do_read(16'h0040, 8'd7, 1);

    // AW delayed 3 cycles with write data offered from the request cycle
    aw_delay = 3;
    wr_q.push_back(32'h0000CAFE);
    wr_q.push_back(32'h0000F00D);
    do_write(16'h0030, 8'd1, 4'hF);
    aw_delay = 0;
    exp_q.push_back(32'h0000CAFE);
    exp_q.push_back(32'h0000F00D);
    do_read(16'h0030, 8'd1, 0);

    // len=255 write and readback
    for (int i = 0; i < 256; i++) wr_q.push_back(32'h1000 + i);
    do_write(16'h0200, 8'd255, 4'hF);
    for (int i = 0; i < 256; i++) exp_q.push_back(32'h1000 + i);
    do_read(16'h0200, 8'd255, 0);

    // reset during beat 2 of a len=3 write
    req_valid = 1; req_write = 1; req_addr = 16'h0300; req_len = 8'd3; req_wstrb = 4'hF;
    cyc();
    req_valid = 0;
    cyc();
    wdata_valid = 1; wdata = 32'h55;
    cyc();
    cyc();
    settle();
    chk("mid_burst_state", dbg_state, WR_DATA);
    rst = 1;
    cyc();
    rst = 0;
    settle();
    chk("mb_awvalid", axi.awvalid, 0);
    chk("mb_wvalid", axi.wvalid, 0);
    chk("mb_bready", axi.bready, 0);
    chk("mb_req_ready", req_ready, 1);
    chk("mb_state", dbg_state, IDLE);
    wdata_valid = 0;
    exp_q.push_back(32'hDEADBEEF);
    do_read(16'h0010, 8'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu2axi.md
Name: cpu2axi

Overview:
- Single-outstanding AXI4 master bridge: converts a simple core-side burst request port into AXI AR/R or AW/W/B transactions.
- Sits directly upstream of the AXI-to-RAM slave: its axi_m port connects to the slave's axi_if.s.
- Addresses are word indices; INCR bursts advance by 1 per beat.
- Read data and write data are streamed with valid/ready on the core side.

Parameters:
- ID_WIDTH, 4, width of ARID/AWID/RID/BID.
- ADDR_WIDTH, 16, word-address width.
- DATA_WIDTH, 32, data bus width.
- BYTE_WIDTH, 8, bits per strobe lane; STRB_W = DATA_WIDTH/BYTE_WIDTH.
- AXI_ID, 0, constant ID driven on ARID/AWID.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  start word address.
- req_len  in  8  beats minus 1 (AXI LEN encoding).
- req_wstrb  in  STRB_W  byte strobe applied to every write beat.
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted.
- wdata  in  DATA_WIDTH  write beat data.
- rdata_valid  out  1  read beat valid.
- rdata_ready  in  1  core accepts read beat.
- rdata  out  DATA_WIDTH  read beat data.
- rdata_last  out  1  final beat of read burst.
- wr_done  out  1  one-cycle pulse on B handshake.
- axi_m  axi_if.m  -  AXI4 master port (AR, R, AW, W, B channels).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- Reset values (applied on clock edge with rst=1, from any state): state=IDLE; req_ready=1 (combinational from IDLE); ARVALID, AWVALID, WVALID, WLAST, BREADY, RREADY, rdata_valid, wdata_ready, wr_done all 0; latched addr/len/strb/beat counter = 0.
- IDLE:
  - req_ready=1.
  - On req handshake: latch addr, len and wstrb, clear beat_cnt, then go to WR_ADDR if req_write else RD_ADDR.
  - No AXI valids asserted.
- RD_ADDR:
  - ARVALID=1, ARID=AXI_ID, ARADDR=latched addr, ARLEN=len.
  - ARSIZE=$clog2(STRB_W), ARBURST=INCR (2'b01).
  - Hold all fields stable until ARREADY. On ARVALID&&ARREADY go to RD_DATA.
- RD_DATA:
  - Pass-through with zero latency: rdata_valid=RVALID, rdata=RDATA, rdata_last=RLAST, RREADY=rdata_ready.
  - On RVALID&&RREADY&&RLAST go to IDLE. Termination is by RLAST only; the beat count is not checked.
- WR_ADDR:
  - AWVALID=1 with the same field rules as AR.
  - W is never driven before the AW handshake: WVALID=0 and wdata_ready=0.
  - On AWVALID&&AWREADY go to WR_DATA.
- WR_DATA:
  - WVALID=wdata_valid, WDATA=wdata, wdata_ready=WREADY, WSTRB=latched strb.
  - WLAST=(beat_cnt==len).
  - Each W handshake increments beat_cnt (8-bit).
  - Handshake with WLAST=1 goes to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID: wr_done pulses 1 for exactly that cycle; go to IDLE. BID/BRESP are ignored.
- Latency:
  - Request to ARVALID/AWVALID: 1 cycle.
  - Last W handshake to BREADY: 1 cycle.
  - Read beats add 0 cycles.
- Boundary conditions:
  - req_len=0: single beat, WLAST asserted on first W beat.
  - req_len=255: beat_cnt reaches 255 without overflow.
  - Address wrap at 2^ADDR_WIDTH is the slave's responsibility; the master does not split bursts.
  - req_valid while busy: req_ready=0, request held off.
  - Reset during any state: next cycle is IDLE with all AXI valids 0, even mid-burst; the slave is assumed reset together.

Decomposition:
- axi_pkg holds:
  - BURST_FIXED/INCR/WRAP constants.
  - The cpu2axi_state_t enum.
  - A size_from_bytes function (clog2).
- No sub-module is natural; a single FSM with one beat counter is sufficient.

Test Plan:
- Single read: req addr=0x0010, len=0 → ARVALID one cycle after request, ARADDR=0x0010, ARLEN=0, ARSIZE=2, ARBURST=1; the one RDATA=0xDEADBEEF appears on rdata with rdata_last=1; back in IDLE, req_ready=1.
- Burst write: addr=0x0100, len=3, wstrb=4'hF, data 1..4 → exactly 4 W beats, WLAST only on the 4th; wr_done pulses once after BVALID; RAM words 0x100..0x103 read back 1..4.
- Backpressure: read len=7 with rdata_ready toggling 1/0 each cycle → 8 beats delivered in order with no loss or duplication; RREADY mirrors rdata_ready.
- Partial strobe: write addr=0x20, len=0, wstrb=4'b0101, wdata=0xAABBCCDD over prior 0x11223344 → readback 0x11BB33DD.
- Ordering: wdata_valid=1 held from the request cycle with AWREADY delayed 3 cycles → WVALID stays 0 until the AW handshake completes.
- Reset mid-burst: rst=1 during beat 2 of a len=3 write → next cycle AWVALID=WVALID=BREADY=0 and req_ready=1; a new read request afterwards completes correctly.
